// File: rtl/spio_hss_multiplexer_rx_pkt_check_pkg.sv
// Shared types and widths for the receive-side packet checker.
// Sequence/packet widths and checker state encodings.
package spio_hss_multiplexer_rx_pkt_check_pkg;

    localparam int SEQ_BITS = 3;
    localparam int PKT_BITS = 16;

    typedef enum logic [1:0] {
        RX_OK,
        RX_NAK_SEND,
        RX_NAK_WAIT
    } rx_state_t;

    function automatic logic [SEQ_BITS-1:0] seq_inc(
        input logic [SEQ_BITS-1:0] s
    );
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/spio_hss_multiplexer_rx_fifo.sv
// First-word-fall-through packet queue with occupancy count.
// Head entry is always visible on pop_data while not empty.
module spio_hss_multiplexer_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spio_hss_multiplexer_rx_pkt_check.sv
// Receive packet checker: in-order acceptance, ack/nak, flow control.
// Accepted packets are queued for the output handshake.
module spio_hss_multiplexer_rx_pkt_check
    import spio_hss_multiplexer_rx_pkt_check_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CFC_MARGIN   = 4,
    parameter int ACK_INTERVAL = 4,
    parameter int NAK_TIMEOUT  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                slot_vld,
    input  logic [SEQ_BITS-1:0] slot_seq,
    input  logic                slot_pres,
    input  logic                slot_crc_ok,
    input  logic [PKT_BITS-1:0] slot_data,
    output logic [PKT_BITS-1:0] pkt_data,
    output logic                pkt_vld,
    input  logic                pkt_rdy,
    output logic                ackn_vld,
    output logic                ackn_nak,
    output logic [SEQ_BITS-1:0] ackn_seq,
    input  logic                ackn_rdy,
    output logic                cfc_loc,
    output logic                empty,
    output logic                full
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int TW  = $clog2(NAK_TIMEOUT);
    localparam int ACW = $clog2(ACK_INTERVAL + 1);

    rx_state_t           state_q, state_d;
    logic [SEQ_BITS-1:0] exp_seq_q, exp_seq_d;
    logic [ACW-1:0]      acc_q, acc_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                vld_d, nak_d, cfc_d;
    logic [CW-1:0]       count;
    logic                accept, reject, push, pop, hs;
    int                  cnt_nxt;

    assign accept = slot_vld & slot_crc_ok
                  & (slot_seq == exp_seq_q)
                  & ~(slot_pres & full);
    assign reject = slot_vld & ~accept;
    assign push   = accept & slot_pres;
    assign pkt_vld = ~empty;
    assign pop    = pkt_vld & pkt_rdy;
    assign hs     = ackn_vld & ackn_rdy;

    spio_hss_multiplexer_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (slot_data),
        .pop       (pop),
        .pop_data  (pkt_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // Sequence tracking and accepted-slot counting for acks.
    always_comb begin
        exp_seq_d = exp_seq_q;
        acc_d     = hs ? '0 : acc_q;
        if (accept) begin
            exp_seq_d = seq_inc(exp_seq_q);
            if (acc_d < ACW'(ACK_INTERVAL)) acc_d = acc_d + 1'b1;
        end
    end

    // Gap recovery state machine with nak re-issue timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            RX_OK: begin
                if (reject) state_d = RX_NAK_SEND;
            end
            RX_NAK_SEND: begin
                if (accept) begin
                    state_d = RX_OK;
                end else if (hs && ackn_nak) begin
                    state_d = RX_NAK_WAIT;
                    timer_d = '0;
                end
            end
            RX_NAK_WAIT: begin
                if (accept) begin
                    state_d = RX_OK;
                end else if (timer_q == TW'(NAK_TIMEOUT - 1)) begin
                    state_d = RX_NAK_SEND;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = RX_OK;
        endcase
    end

    // Next ack/nak request and flow-control decision.
    always_comb begin
        nak_d   = (state_d == RX_NAK_SEND);
        vld_d   = nak_d
                | ((state_d == RX_OK) && (acc_d >= ACW'(ACK_INTERVAL)));
        cnt_nxt = int'(count) + int'(push) - int'(pop);
        cfc_d   = (FIFO_DEPTH - cnt_nxt) >= CFC_MARGIN;
    end

    // Registered state and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_OK;
            exp_seq_q <= '0;
            acc_q     <= '0;
            timer_q   <= '0;
            ackn_vld  <= 1'b0;
            ackn_nak  <= 1'b0;
            ackn_seq  <= '0;
            cfc_loc   <= 1'b1;
        end else begin
            state_q   <= state_d;
            exp_seq_q <= exp_seq_d;
            acc_q     <= acc_d;
            timer_q   <= timer_d;
            ackn_vld  <= vld_d;
            ackn_nak  <= nak_d;
            ackn_seq  <= exp_seq_d;
            cfc_loc   <= cfc_d;
        end
    end

endmodule

// File: tb/tb_spio_hss_multiplexer_rx_pkt_check.sv
// Directed bench for the receive packet checker.
// Expected values are hand-derived per step.
module tb_spio_hss_multiplexer_rx_pkt_check;
    import spio_hss_multiplexer_rx_pkt_check_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                slot_vld = 1'b0;
    logic [SEQ_BITS-1:0] slot_seq = '0;
    logic                slot_pres = 1'b0;
    logic                slot_crc_ok = 1'b0;
    logic [PKT_BITS-1:0] slot_data = '0;
    logic [PKT_BITS-1:0] pkt_data;
    logic                pkt_vld;
    logic                pkt_rdy = 1'b0;
    logic                ackn_vld;
    logic                ackn_nak;
    logic [SEQ_BITS-1:0] ackn_seq;
    logic                ackn_rdy = 1'b0;
    logic                cfc_loc;
    logic                empty;
    logic                full;

    int errors = 0;
    int checks = 0;
    int pkt_cnt = 0;
    int nak_cnt = 0;
    int snap_p;
    int snap_n;
    int wait_n;

    spio_hss_multiplexer_rx_pkt_check dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot_vld    (slot_vld),
        .slot_seq    (slot_seq),
        .slot_pres   (slot_pres),
        .slot_crc_ok (slot_crc_ok),
        .slot_data   (slot_data),
        .pkt_data    (pkt_data),
        .pkt_vld     (pkt_vld),
        .pkt_rdy     (pkt_rdy),
        .ackn_vld    (ackn_vld),
        .ackn_nak    (ackn_nak),
        .ackn_seq    (ackn_seq),
        .ackn_rdy    (ackn_rdy),
        .cfc_loc     (cfc_loc),
        .empty       (empty),
        .full        (full)
    );

    always #5 clk = ~clk;

    // Count handshakes using values that are stable before each edge.
    always @(negedge clk) begin
        if (pkt_vld && pkt_rdy) pkt_cnt <= pkt_cnt + 1;
        if (ackn_vld && ackn_rdy && ackn_nak) nak_cnt <= nak_cnt + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int seq, input bit pres,
                        input bit crc, input int data);
        slot_vld    = 1'b1;
        slot_seq    = SEQ_BITS'(seq);
        slot_pres   = pres;
        slot_crc_ok = crc;
        slot_data   = PKT_BITS'(data);
        tick();
        slot_vld    = 1'b0;
    endtask

    task automatic do_reset();
        slot_vld = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pkt_vld"}, pkt_vld, 0);
        chk({tag, "_ackn_vld"}, ackn_vld, 0);
        chk({tag, "_ackn_nak"}, ackn_nak, 0);
        chk({tag, "_ackn_seq"}, ackn_seq, 0);
        chk({tag, "_cfc"}, cfc_loc, 1);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
    endtask

    initial begin
        do_reset();
        chk_reset("rst");

        // In-order stream with an ack after the 4th accept.
        pkt_rdy  = 1'b1;
        ackn_rdy = 1'b1;
        snap_p   = pkt_cnt;
        for (int i = 0; i < 5; i++) begin
            send(i, 1, 1, 'hA000 + i);
            chk("a_vld", pkt_vld, 1);
            chk("a_data", pkt_data, 'hA000 + i);
            if (i == 3) begin
                chk("a_ack_vld", ackn_vld, 1);
                chk("a_ack_nak", ackn_nak, 0);
                chk("a_ack_seq", ackn_seq, 4);
            end
            if (i == 4) chk("a_ack_drop", ackn_vld, 0);
        end
        repeat (2) tick();
        chk("a_count", pkt_cnt - snap_p, 5);
        chk("a_empty", empty, 1);

        // Lost seq 2, then retransmission of 2 and 3.
        do_reset();
        snap_p = pkt_cnt;
        send(0, 1, 1, 'hB000);
        send(1, 1, 1, 'hB001);
        send(3, 1, 1, 'hB003);
        chk("b_nak_vld", ackn_vld, 1);
        chk("b_nak", ackn_nak, 1);
        chk("b_nak_seq", ackn_seq, 2);
        chk("b_drop", pkt_vld, 0);
        send(2, 1, 1, 'hB002);
        chk("b_r2", pkt_data, 'hB002);
        chk("b_ok", ackn_vld, 0);
        send(3, 1, 1, 'hB003);
        chk("b_r3", pkt_data, 'hB003);
        repeat (2) tick();
        chk("b_count", pkt_cnt - snap_p, 4);

        // CRC error on seq 5 yields one nak; 6 and 7 dropped.
        do_reset();
        for (int i = 0; i < 5; i++) send(i, 1, 1, 'hC000 + i);
        snap_n = nak_cnt;
        send(5, 1, 0, 'hC005);
        chk("c_nak_vld", ackn_vld, 1);
        chk("c_nak", ackn_nak, 1);
        chk("c_nak_seq", ackn_seq, 5);
        snap_p = pkt_cnt;
        send(6, 1, 1, 'hC006);
        send(7, 1, 1, 'hC007);
        repeat (3) tick();
        chk("c_one_nak", nak_cnt - snap_n, 1);
        chk("c_no_pkt", pkt_cnt - snap_p, 0);
        chk("c_quiet", ackn_vld, 0);

        // Nak re-issued after the timeout with no retransmission.
        do_reset();
        send(1, 1, 1, 'hD001);
        chk("d_nak1", ackn_vld, 1);
        tick();
        chk("d_taken", ackn_vld, 0);
        wait_n = 0;
        while (!ackn_vld && wait_n < 1000) begin
            tick();
            wait_n++;
        end
        chk("d_timeout", wait_n, 256);
        chk("d_nak2", ackn_nak, 1);
        chk("d_nak2_seq", ackn_seq, 0);

        // Fill with downstream stalled, overflow reject, then drain.
        do_reset();
        pkt_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(i, 1, 1, 'hE000 + i);
            if (i == 3) chk("e_cfc4", cfc_loc, 1);
            if (i == 4) chk("e_cfc5", cfc_loc, 0);
        end
        chk("e_full", full, 1);
        chk("e_head", pkt_data, 'hE000);
        send(0, 1, 1, 'hDEAD);
        chk("e_ovf_nak", ackn_vld & ackn_nak, 1);
        chk("e_ovf_seq", ackn_seq, 0);
        chk("e_hold", pkt_data, 'hE000);
        chk("e_still", full, 1);
        pkt_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("e_dvld", pkt_vld, 1);
            chk("e_ddata", pkt_data, 'hE000 + i);
            tick();
        end
        chk("e_empty", empty, 1);
        chk("e_cfc", cfc_loc, 1);

        // Sequence wrap with ack held pending, then async reset.
        do_reset();
        ackn_rdy = 1'b0;
        for (int i = 0; i < 7; i++) send(i, 1, 1, 'hF000 + i);
        send(7, 1, 1, 'hF007);
        chk("f_d7", pkt_data, 'hF007);
        chk("f_seq7", ackn_seq, 0);
        chk("f_ack", ackn_vld, 1);
        send(0, 1, 1, 'hF100);
        chk("f_d0", pkt_data, 'hF100);
        chk("f_wrap", ackn_seq, 1);
        chk("f_acknak", ackn_nak, 0);
        pkt_rdy = 1'b0;
        send(1, 1, 1, 'hF101);
        send(2, 1, 1, 'hF102);
        chk("f_busy", empty, 0);
        rst_n = 1'b0;
        #2;
        chk_reset("mid");
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
